if_stage: RTL

Instruction-fetch stage of the MIPS pipeline: owns the PC, issues one-outstanding-request fetches to instruction memory, and holds the IF/ID pipeline register whose instruction feeds the control unit's decode. It applies the control unit's `pcwrite`/`j`/`jal`/`jr` outputs and the EX-stage branch resolution as PC redirects. There are no delay slots: every redirect flushes wrong-path fetches.

---
 rtl/mips_pkg.sv | 26 ++
 rtl/if_redirect_mux.sv | 32 +++
 rtl/if_stage.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: definitions shared by the MIPS pipeline blocks.
//   RESET_PC_DEFAULT  PC value loaded on reset
//   if_state_t        fetch FSM states (IDLE / WAIT / KILL)
//   OP_* / FUNCT_JR   opcode and funct values of the jump instructions
//   jump_target()     J/JAL target: {pc4[31:28], index[25:0], 2'b00}
package mips_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        KILL = 2'd2
    } if_state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] FUNCT_JR = 6'b001000;

    function automatic logic [31:0] jump_target(input logic [3:0]  pc4_region,
                                                input logic [25:0] jump_index);
        return {pc4_region, jump_index, 2'b00};
    endfunction

endpackage

// File: rtl/if_redirect_mux.sv
// if_redirect_mux: combinational priority select of the PC redirect.
//   branch_taken/branch_target  EX-stage branch (oldest, highest priority)
//   jr/jr_target                register jump decoded in IF/ID
//   j/jal + pc4_region/jump_index  absolute jump decoded in IF/ID
//   redirect                    any redirect active this cycle
//   redirect_target             selected new PC
module if_redirect_mux
    import mips_pkg::*;
(
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jr,
    input  logic [31:0] jr_target,
    input  logic        j,
    input  logic        jal,
    input  logic [3:0]  pc4_region,
    input  logic [25:0] jump_index,
    output logic        redirect,
    output logic [31:0] redirect_target
);

    always_comb begin
        redirect        = branch_taken | jr | j | jal;
        redirect_target = jump_target(pc4_region, jump_index);
        if (branch_taken) begin
            redirect_target = branch_target;
        end else if (jr) begin
            redirect_target = jr_target;
        end
    end

endmodule

// File: rtl/if_stage.sv
// if_stage: instruction fetch stage. Owns the PC, keeps at most one
// instruction-memory request outstanding and holds the IF/ID register.
//   clk, rst                     clock, async active-high reset
//   pcwrite, stall               hold PC and IF/ID when pcwrite=0 or stall=1
//   branch_taken/branch_target   EX-stage redirect
//   j, jal, jr, jr_target        IF/ID-stage redirects
//   imem_req/imem_addr           fetch request (accepted when high)
//   imem_rvalid/imem_rdata       fetch response
//   ifid_inst/ifid_pc4/ifid_valid  IF/ID pipeline register
module if_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        pcwrite,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        j,
    input  logic        jal,
    input  logic        jr,
    input  logic [31:0] jr_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ifid_inst,
    output logic [31:0] ifid_pc4,
    output logic        ifid_valid
);

    if_state_t   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        skid_full_q, skid_full_d;
    logic [31:0] skid_inst_q, skid_inst_d;
    logic [31:0] skid_pc4_q, skid_pc4_d;
    logic [31:0] ifid_inst_q, ifid_inst_d;
    logic [31:0] ifid_pc4_q, ifid_pc4_d;
    logic        ifid_valid_q, ifid_valid_d;

    logic        hold;
    logic        redirect;
    logic [31:0] redirect_target;
    logic [31:0] pc_plus4;
    logic        resp_take;
    logic        chain;
    logic        req_raw;

    if_redirect_mux u_redirect_mux (
        .branch_taken    (branch_taken),
        .branch_target   (branch_target),
        .jr              (jr),
        .jr_target       (jr_target),
        .j               (j),
        .jal             (jal),
        .pc4_region      (ifid_pc4_q[31:28]),
        .jump_index      (ifid_inst_q[25:0]),
        .redirect        (redirect),
        .redirect_target (redirect_target)
    );

    always_comb begin
        hold      = stall | ~pcwrite;
        pc_plus4  = pc_q + 32'd4;
        // A response for the current PC that survives (not being redirected).
        resp_take = (state_q == WAIT) & imem_rvalid & ~redirect;
        // Response goes straight into IF/ID and the next fetch issues at once.
        chain     = resp_take & ~hold & ~skid_full_q;

        state_d      = state_q;
        pc_d         = pc_q;
        skid_full_d  = skid_full_q;
        skid_inst_d  = skid_inst_q;
        skid_pc4_d   = skid_pc4_q;
        ifid_inst_d  = ifid_inst_q;
        ifid_pc4_d   = ifid_pc4_q;
        ifid_valid_d = ifid_valid_q;
        req_raw      = 1'b0;
        imem_addr    = pc_q;

        case (state_q)
            IDLE: begin
                if (!redirect && !skid_full_q) begin
                    req_raw = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    if (chain) begin
                        req_raw   = 1'b1;
                        imem_addr = pc_plus4;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (redirect) begin
                    state_d = KILL;
                end
            end
            KILL: begin
                if (imem_rvalid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (redirect) begin
            pc_d = redirect_target;
        end else if (resp_take) begin
            pc_d = pc_plus4;
        end

        if (redirect) begin
            ifid_inst_d  = 32'd0;
            ifid_pc4_d   = 32'd0;
            ifid_valid_d = 1'b0;
            skid_full_d  = 1'b0;
        end else begin
            if (!hold) begin
                if (skid_full_q) begin
                    ifid_inst_d  = skid_inst_q;
                    ifid_pc4_d   = skid_pc4_q;
                    ifid_valid_d = 1'b1;
                    skid_full_d  = 1'b0;
                end else if (resp_take) begin
                    ifid_inst_d  = imem_rdata;
                    ifid_pc4_d   = pc_plus4;
                    ifid_valid_d = 1'b1;
                end else begin
                    ifid_inst_d  = 32'd0;
                    ifid_pc4_d   = 32'd0;
                    ifid_valid_d = 1'b0;
                end
            end
            // Response that cannot go straight to IF/ID is parked.
            if (resp_take && !chain) begin
                skid_full_d = 1'b1;
                skid_inst_d = imem_rdata;
                skid_pc4_d  = pc_plus4;
            end
        end
    end

    // No request may escape while reset is held, even though IDLE would ask.
    assign imem_req   = req_raw & ~rst;
    assign ifid_inst  = ifid_inst_q;
    assign ifid_pc4   = ifid_pc4_q;
    assign ifid_valid = ifid_valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            skid_full_q  <= 1'b0;
            skid_inst_q  <= 32'd0;
            skid_pc4_q   <= 32'd0;
            ifid_inst_q  <= 32'd0;
            ifid_pc4_q   <= 32'd0;
            ifid_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            skid_full_q  <= skid_full_d;
            skid_inst_q  <= skid_inst_d;
            skid_pc4_q   <= skid_pc4_d;
            ifid_inst_q  <= ifid_inst_d;
            ifid_pc4_q   <= ifid_pc4_d;
            ifid_valid_q <= ifid_valid_d;
        end
    end

endmodule
